// File: rtl/seg_pkg.sv
// Shared types and constants for the 7-segment scan path.
// State encoding, digit geometry, anode constants and the anode decode helper.
package seg_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    BLANK = 2'd1,
    ON    = 2'd2
  } state_t;

  localparam int NUM_DIGITS  = 8;
  localparam int DIGIT_SEL_W = 3;

  localparam logic [NUM_DIGITS-1:0] AN_OFF = 8'hFF;

  // Active-low one-hot anode pattern for digit i.
  function automatic logic [NUM_DIGITS-1:0] an_sel(
    input logic [DIGIT_SEL_W-1:0] i
  );
    logic [NUM_DIGITS-1:0] one;
    one = {{(NUM_DIGITS-1){1'b0}}, 1'b1};
    return ~(one << i);
  endfunction

endpackage

// File: rtl/next_digit_sel.sv
// Rotate-priority finder: first set mask bit searching upward from cur+1.
// Ports: cur (current index), mask (enabled digits) -> nxt, wrap (nxt <= cur).
module next_digit_sel
  import seg_pkg::*;
(
  input  logic [DIGIT_SEL_W-1:0] cur,
  input  logic [NUM_DIGITS-1:0]  mask,
  output logic [DIGIT_SEL_W-1:0] nxt,
  output logic                   wrap
);

  logic [DIGIT_SEL_W-1:0] idx;
  logic                   found;

  // Offset 8 lands back on cur, so a lone enabled digit selects itself.
  always_comb begin
    nxt   = cur;
    found = 1'b0;
    idx   = '0;
    for (int i = 1; i <= NUM_DIGITS; i++) begin
      idx = cur + DIGIT_SEL_W'(i);
      if (!found && mask[idx]) begin
        nxt   = idx;
        found = 1'b1;
      end
    end
  end

  assign wrap = (nxt <= cur);

endmodule

// File: rtl/seg_scan_ctrl.sv
// Digit-scan controller: blanked, time-multiplexed 8-digit anode/dp drive.
// Ports: clk, rst, en, digit_mask, dp_mask -> s, an, dp, scan_tick, frame_done.
module seg_scan_ctrl
  import seg_pkg::*;
#(
  parameter int CLK_HZ    = 100_000_000,
  parameter int SCAN_HZ   = 1_000,
  parameter int BLANK_CYC = 1_000
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   en,
  input  logic [NUM_DIGITS-1:0]  digit_mask,
  input  logic [NUM_DIGITS-1:0]  dp_mask,
  output logic [DIGIT_SEL_W-1:0] s,
  output logic [NUM_DIGITS-1:0]  an,
  output logic                   dp,
  output logic                   scan_tick,
  output logic                   frame_done
);

  localparam int DIV = CLK_HZ / SCAN_HZ;
  localparam int PW  = (DIV > 1) ? $clog2(DIV) : 1;

  localparam logic [PW-1:0] DIV_LAST   = PW'(DIV - 1);
  localparam logic [PW-1:0] BLANK_LAST = PW'(BLANK_CYC - 1);

  if (BLANK_CYC >= DIV || BLANK_CYC < 1) begin : g_bad_blank
    $error("BLANK_CYC must be in 1..DIV-1");
  end

  state_t                 state;
  logic [PW-1:0]          pre;
  logic [DIGIT_SEL_W-1:0] nxt;
  logic                   wrap;

  next_digit_sel u_nxt (
    .cur  (s),
    .mask (digit_mask),
    .nxt  (nxt),
    .wrap (wrap)
  );

  // The prescaler spans the whole slot; BLANK is its first
  // BLANK_CYC counts, ON the remainder up to DIV-1.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      s          <= '0;
      pre        <= '0;
      an         <= AN_OFF;
      dp         <= 1'b1;
      scan_tick  <= 1'b0;
      frame_done <= 1'b0;
    end else begin
      scan_tick  <= 1'b0;
      frame_done <= 1'b0;
      an         <= AN_OFF;
      dp         <= 1'b1;
      if (!en || digit_mask == '0) begin
        state <= IDLE;
        pre   <= '0;
      end else begin
        unique case (state)
          IDLE: begin
            pre   <= '0;
            state <= BLANK;
            if (!digit_mask[s]) s <= nxt;
          end
          BLANK: begin
            pre <= pre + 1'b1;
            if (pre == BLANK_LAST) begin
              state <= ON;
              if (digit_mask[s]) begin
                an <= an_sel(s);
                dp <= ~dp_mask[s];
              end
            end
          end
          ON: begin
            if (pre == DIV_LAST) begin
              pre        <= '0;
              s          <= nxt;
              scan_tick  <= 1'b1;
              frame_done <= wrap;
              state      <= BLANK;
            end else begin
              pre <= pre + 1'b1;
              if (digit_mask[s]) begin
                an <= an_sel(s);
                dp <= ~dp_mask[s];
              end
            end
          end
          default: begin
            state <= IDLE;
            pre   <= '0;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_seg_scan_ctrl.sv
// Directed bench for seg_scan_ctrl (DIV=10, BLANK_CYC=2).
// Scenario tasks compare {s,an,dp,scan_tick,frame_done} per cycle.
module tb_seg_scan_ctrl;

  logic       clk = 1'b0;
  logic       rst;
  logic       en;
  logic [7:0] digit_mask;
  logic [7:0] dp_mask;
  logic [2:0] s;
  logic [7:0] an;
  logic       dp;
  logic       scan_tick;
  logic       frame_done;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  seg_scan_ctrl #(
    .CLK_HZ    (1000),
    .SCAN_HZ   (100),
    .BLANK_CYC (2)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .en         (en),
    .digit_mask (digit_mask),
    .dp_mask    (dp_mask),
    .s          (s),
    .an         (an),
    .dp         (dp),
    .scan_tick  (scan_tick),
    .frame_done (frame_done)
  );

  function automatic logic [2:0] ref_next(input logic [2:0] c,
                                          input logic [7:0] m);
    logic [2:0] k;
    for (int i = 1; i <= 8; i++) begin
      k = c + 3'(i);
      if (m[k]) return k;
    end
    return c;
  endfunction

  // Expected {s,an,dp,tick,fd} at cycle c (c=1 is the first edge with en=1).
  function automatic logic [13:0] ref_vec(input int c, input logic [7:0] m,
                                          input logic [7:0] dpm);
    int slot, ph;
    logic [2:0] cur, prv;
    logic [7:0] a;
    logic d, t, f;
    slot = (c - 1) / 10;
    ph   = (c - 1) % 10;
    cur  = m[0] ? 3'd0 : ref_next(3'd0, m);
    prv  = cur;
    for (int j = 0; j < slot; j++) begin
      prv = cur;
      cur = ref_next(cur, m);
    end
    a = 8'hFF;
    d = 1'b1;
    if (ph >= 2) begin
      a = 8'hFF;
      a[cur] = 1'b0;
      d = ~dpm[cur];
    end
    t = (slot > 0) && (ph == 0);
    f = t && (cur <= prv);
    return {cur, a, d, t, f};
  endfunction

  function automatic logic [13:0] got_vec();
    return {s, an, dp, scan_tick, frame_done};
  endfunction

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    en = 1'b0;
    digit_mask = 8'h00;
    dp_mask = 8'h00;
    repeat (2) @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_reset();
    logic [13:0] g;
    @(negedge clk);
    rst = 1'b1;
    en = 1'b1;
    digit_mask = 8'hFF;
    dp_mask = 8'hFF;
    repeat (3) @(negedge clk);
    g = got_vec();
    checks++;
    if (g !== {3'd0, 8'hFF, 1'b1, 1'b0, 1'b0}) begin
      errors++;
      $display("FAIL reset_state got=%h exp=%h", g,
               {3'd0, 8'hFF, 1'b1, 1'b0, 1'b0});
    end
    rst = 1'b0;
    en = 1'b0;
  endtask

  task automatic test_full_scan();
    logic [13:0] g, e;
    do_reset();
    en = 1'b1;
    digit_mask = 8'hFF;
    for (int c = 1; c <= 92; c++) begin
      @(negedge clk);
      g = got_vec();
      e = ref_vec(c, 8'hFF, 8'h00);
      checks++;
      if (g !== e) begin
        errors++;
        $display("FAIL full_scan c=%0d got=%h exp=%h", c, g, e);
      end
    end
  endtask

  task automatic test_sparse_mask();
    logic [13:0] g, e;
    do_reset();
    en = 1'b1;
    digit_mask = 8'b1000_0101;
    for (int c = 1; c <= 45; c++) begin
      @(negedge clk);
      g = got_vec();
      e = ref_vec(c, 8'b1000_0101, 8'h00);
      checks++;
      if (g !== e || (an & 8'b0111_1010) !== 8'b0111_1010) begin
        errors++;
        $display("FAIL sparse_mask c=%0d got=%h exp=%h", c, g, e);
      end
    end
  endtask

  task automatic test_single_digit();
    logic [13:0] g, e;
    do_reset();
    en = 1'b1;
    digit_mask = 8'h10;
    for (int c = 1; c <= 32; c++) begin
      @(negedge clk);
      g = got_vec();
      e = ref_vec(c, 8'h10, 8'h00);
      checks++;
      if (g !== e) begin
        errors++;
        $display("FAIL single_digit c=%0d got=%h exp=%h", c, g, e);
      end
    end
  endtask

  task automatic test_dp();
    logic [13:0] g, e;
    do_reset();
    en = 1'b1;
    digit_mask = 8'hFF;
    dp_mask = 8'h04;
    for (int c = 1; c <= 40; c++) begin
      @(negedge clk);
      g = got_vec();
      e = ref_vec(c, 8'hFF, 8'h04);
      checks++;
      if (g !== e) begin
        errors++;
        $display("FAIL dp_mask c=%0d got=%h exp=%h", c, g, e);
      end
    end
  endtask

  task automatic test_en_drop();
    logic [13:0] g, e;
    do_reset();
    en = 1'b1;
    digit_mask = 8'hFF;
    repeat (35) @(negedge clk);
    en = 1'b0;
    for (int k = 1; k <= 5; k++) begin
      @(negedge clk);
      g = got_vec();
      e = {3'd3, 8'hFF, 1'b1, 1'b0, 1'b0};
      checks++;
      if (g !== e) begin
        errors++;
        $display("FAIL en_drop k=%0d got=%h exp=%h", k, g, e);
      end
    end
    en = 1'b1;
    for (int k = 1; k <= 11; k++) begin
      @(negedge clk);
      g = got_vec();
      if (k <= 2)
        e = {3'd3, 8'hFF, 1'b1, 1'b0, 1'b0};
      else if (k <= 10)
        e = {3'd3, 8'hF7, 1'b1, 1'b0, 1'b0};
      else
        e = {3'd4, 8'hFF, 1'b1, 1'b1, 1'b0};
      checks++;
      if (g !== e) begin
        errors++;
        $display("FAIL en_resume k=%0d got=%h exp=%h", k, g, e);
      end
    end
  endtask

  task automatic test_rst_mid_slot();
    logic [13:0] g, e;
    do_reset();
    en = 1'b1;
    digit_mask = 8'hFF;
    repeat (55) @(negedge clk);
    checks++;
    if (s !== 3'd5 || an !== 8'hDF) begin
      errors++;
      $display("FAIL pre_rst got s=%0d an=%h exp s=5 an=df", s, an);
    end
    #1 rst = 1'b1;
    #1;
    g = got_vec();
    e = {3'd0, 8'hFF, 1'b1, 1'b0, 1'b0};
    checks++;
    if (g !== e) begin
      errors++;
      $display("FAIL async_rst got=%h exp=%h", g, e);
    end
    @(negedge clk);
    rst = 1'b0;
    for (int c = 1; c <= 13; c++) begin
      @(negedge clk);
      g = got_vec();
      e = ref_vec(c, 8'hFF, 8'h00);
      checks++;
      if (g !== e) begin
        errors++;
        $display("FAIL rst_restart c=%0d got=%h exp=%h", c, g, e);
      end
    end
  endtask

  initial begin
    rst = 1'b1;
    en = 1'b0;
    digit_mask = 8'h00;
    dp_mask = 8'h00;
    test_reset();
    test_full_scan();
    test_sparse_mask();
    test_single_digit();
    test_dp();
    test_en_drop();
    test_rst_mid_slot();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
